// File: rtl/sparse_cnn_pkg.sv
// Shared types, default sizes and the signed saturation helper for the sparse CNN PE.
package sparse_cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pe_state_t;

    localparam int unsigned LANES_DEF   = 4;
    localparam int unsigned WL_DEF      = 16;
    localparam int unsigned DWL_DEF     = 32;
    localparam int unsigned CW_DEF      = 5;
    localparam int unsigned OUT_DIM_DEF = 28;
    localparam int unsigned CHW_DEF     = 6;
    localparam int unsigned NW_DEF      = 8;
    localparam int unsigned SAT_W       = 64;

    // Clamp a sign-extended value into the signed range of a dwl-bit word.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             dwl
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (dwl - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sparse_lane_mac.sv
// One lane of the Cartesian product: signed multiply, wrap or saturate, coordinate add, bounds mask.
// Saturation is selected with SPARSE_PE_SAT_EN; the default build wraps.
module sparse_lane_mac
    import sparse_cnn_pkg::*;
#(
    parameter int unsigned WL      = WL_DEF,
    parameter int unsigned DWL     = DWL_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned OUT_DIM = OUT_DIM_DEF
) (
    input  logic [WL-1:0]  act,
    input  logic [WL-1:0]  weight,
    input  logic [CW-1:0]  act_row,
    input  logic [CW-1:0]  act_col,
    input  logic [CW-1:0]  w_row,
    input  logic [CW-1:0]  w_col,
    input  logic           act_mask,
    output logic [DWL-1:0] prod_c,
    output logic [CW-1:0]  row_c,
    output logic [CW-1:0]  col_c,
    output logic           mask_c
);

    logic signed [2*WL-1:0] prod_full;
    logic [DWL-1:0]         prod_red;
    logic [CW:0]            row_sum;
    logic [CW:0]            col_sum;
    logic                   in_bounds;

    assign prod_full = (2*WL)'($signed(act)) * (2*WL)'($signed(weight));

`ifdef SPARSE_PE_SAT_EN
    assign prod_red = DWL'(sat_signed(SAT_W'(prod_full), DWL));
`else
    assign prod_red = DWL'(prod_full);
`endif

    // Sums carry one extra bit so an overflow past the plane edge is still detected.
    assign row_sum   = {1'b0, act_row} + {1'b0, w_row};
    assign col_sum   = {1'b0, act_col} + {1'b0, w_col};
    assign in_bounds = (row_sum < (CW+1)'(OUT_DIM)) && (col_sum < (CW+1)'(OUT_DIM));

    assign prod_c = act_mask ? prod_red : '0;
    assign row_c  = row_sum[CW-1:0];
    assign col_c  = col_sum[CW-1:0];
    assign mask_c = act_mask && in_bounds;

endmodule

// File: rtl/sparse_cartesian_pe.sv
// Sparse Cartesian-product PE: one activation bundle times a stream of weights, one bundle per cycle.
// Optional product saturation with SPARSE_PE_SAT_EN (default: two's-complement wrap).
module sparse_cartesian_pe
    import sparse_cnn_pkg::*;
#(
    parameter int unsigned LANES   = LANES_DEF,
    parameter int unsigned WL      = WL_DEF,
    parameter int unsigned DWL     = DWL_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned OUT_DIM = OUT_DIM_DEF,
    parameter int unsigned CHW     = CHW_DEF,
    parameter int unsigned NW      = NW_DEF
) (
    input  logic                 clk,
    input  logic                 irst,
    input  logic                 act_valid,
    output logic                 act_ready,
    input  logic [LANES*WL-1:0]  act_data,
    input  logic [LANES*CW-1:0]  act_rows,
    input  logic [LANES*CW-1:0]  act_cols,
    input  logic [LANES-1:0]     act_mask,
    input  logic [CHW-1:0]       act_channel,
    input  logic [NW-1:0]        w_count,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [WL-1:0]        weight,
    input  logic [CW-1:0]        w_row,
    input  logic [CW-1:0]        w_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*DWL-1:0] data_out,
    output logic [LANES*CW-1:0]  out_rows,
    output logic [LANES*CW-1:0]  out_cols,
    output logic [LANES-1:0]     out_mask,
    output logic [CHW-1:0]       out_channel,
    output logic [NW-1:0]        curr_weight,
    output logic                 busy
);

    pe_state_t state;
    pe_state_t state_next;

    logic [LANES*WL-1:0]  act_data_q;
    logic [LANES*CW-1:0]  act_rows_q;
    logic [LANES*CW-1:0]  act_cols_q;
    logic [LANES-1:0]     act_mask_q;
    logic [CHW-1:0]       act_channel_q;
    logic [NW-1:0]        w_count_q;

    logic [LANES*DWL-1:0] lane_prod;
    logic [LANES*CW-1:0]  lane_row;
    logic [LANES*CW-1:0]  lane_col;
    logic [LANES-1:0]     lane_mask;

    logic act_fire;
    logic w_fire;
    logic w_last;

    assign act_ready = (state == ST_IDLE);
    assign w_ready   = (state == ST_RUN) && (!out_valid || out_ready);
    assign busy      = (state != ST_IDLE);
    assign act_fire  = act_valid && act_ready;
    assign w_fire    = w_valid && w_ready;
    assign w_last    = ((curr_weight + NW'(1)) == w_count_q);

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        sparse_lane_mac #(
            .WL      (WL),
            .DWL     (DWL),
            .CW      (CW),
            .OUT_DIM (OUT_DIM)
        ) u_mac (
            .act      (act_data_q[i*WL +: WL]),
            .weight   (weight),
            .act_row  (act_rows_q[i*CW +: CW]),
            .act_col  (act_cols_q[i*CW +: CW]),
            .w_row    (w_row),
            .w_col    (w_col),
            .act_mask (act_mask_q[i]),
            .prod_c   (lane_prod[i*DWL +: DWL]),
            .row_c    (lane_row[i*CW +: CW]),
            .col_c    (lane_col[i*CW +: CW]),
            .mask_c   (lane_mask[i])
        );
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (act_fire && (w_count != '0)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire && w_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Activation capture, weight counter and the single output register stage.
    always_ff @(posedge clk) begin
        if (irst) begin
            act_data_q    <= '0;
            act_rows_q    <= '0;
            act_cols_q    <= '0;
            act_mask_q    <= '0;
            act_channel_q <= '0;
            w_count_q     <= '0;
            curr_weight   <= '0;
            out_valid     <= 1'b0;
            data_out      <= '0;
            out_rows      <= '0;
            out_cols      <= '0;
            out_mask      <= '0;
            out_channel   <= '0;
        end else begin
            if (act_fire) begin
                act_data_q    <= act_data;
                act_rows_q    <= act_rows;
                act_cols_q    <= act_cols;
                act_mask_q    <= act_mask;
                act_channel_q <= act_channel;
                w_count_q     <= w_count;
                curr_weight   <= '0;
            end
            if (w_fire) begin
                out_valid   <= 1'b1;
                data_out    <= lane_prod;
                out_rows    <= lane_row;
                out_cols    <= lane_col;
                out_mask    <= lane_mask;
                out_channel <= act_channel_q;
                curr_weight <= curr_weight + NW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
